// File: rtl/isa_dma_arbiter_if.sv
// ISA DMA request/acknowledge lines plus the handshake to the ISA cycle engine.
// The arbiter takes the master modport; the ISA side and engine take the slave.
interface isa_dma_arbiter_if;
  logic [3:0] drq;
  logic [3:0] dack_n;
  logic       xfer_req;
  logic [1:0] xfer_ch;
  logic       xfer_wide;
  logic       xfer_done;

  modport master (
    input  drq,
    input  xfer_done,
    output dack_n,
    output xfer_req,
    output xfer_ch,
    output xfer_wide
  );

  modport slave (
    output drq,
    output xfer_done,
    input  dack_n,
    input  xfer_req,
    input  xfer_ch,
    input  xfer_wide
  );
endinterface

// File: rtl/isa_dma_arbiter.sv
// Four-channel ISA DMA arbiter: rotating-priority grant, per-channel transfer
// counters with sticky terminal count, wait timeout and a fixed idle gap between grants.
module isa_dma_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  isa_dma_arbiter_if.master   bus,
  input  logic [3:0]          ch_en,
  input  logic                cnt_load,
  input  logic [1:0]          cnt_ch,
  input  logic [15:0]         cnt_value,
  input  logic [3:0]          tc_clr,
  output logic [3:0]          tc,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, GAP} state_t;

  state_t      state;
  logic [3:0]  drq_s1;
  logic [3:0]  drq_s2;
  logic [1:0]  last_grant;
  logic [7:0]  wait_cnt;
  logic [3:0]  gap_cnt;
  logic [15:0] cnt_q [4];
  logic [3:0]  eligible;
  logic [1:0]  win;
  logic        win_valid;
  logic [1:0]  cand;
  logic        done_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drq_s1 <= '0;
      drq_s2 <= '0;
    end else begin
      drq_s1 <= bus.drq;
      drq_s2 <= drq_s1;
    end
  end

  assign eligible = drq_s2 & ch_en & ~tc;
  assign done_hit = (state == WAIT) && bus.xfer_done;

  // Search starts one past the last winner so every eligible channel gets a turn.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < 4; i++) begin
      cand = last_grant + 2'(i + 1);
      if (!win_valid && eligible[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= 2'd3;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      bus.dack_n    <= 4'hF;
      bus.xfer_req  <= 1'b0;
      bus.xfer_ch   <= 2'd0;
      bus.xfer_wide <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state         <= GRANT;
            last_grant    <= win;
            bus.xfer_ch   <= win;
            bus.xfer_wide <= win[1];
            bus.dack_n    <= ~(4'b0001 << win);
            bus.xfer_req  <= 1'b1;
            busy          <= 1'b1;
          end
        end
        GRANT: begin
          state        <= WAIT;
          bus.xfer_req <= 1'b0;
          wait_cnt     <= '0;
        end
        WAIT: begin
          if (bus.xfer_done) begin
            state      <= GAP;
            bus.dack_n <= 4'hF;
            gap_cnt    <= '0;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            state       <= GAP;
            bus.dack_n  <= 4'hF;
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A software load beats a completion decrement on the same channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_load && cnt_ch == 2'(i))
          cnt_q[i] <= cnt_value;
        else if (done_hit && bus.xfer_ch == 2'(i))
          cnt_q[i] <= cnt_q[i] - 16'd1;
      end
    end
  end

  // Terminal count set outranks a clear strobe; a load clears and suppresses the set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_load && cnt_ch == 2'(i))
          tc[i] <= 1'b0;
        else if (done_hit && bus.xfer_ch == 2'(i) && cnt_q[i] == 16'd0)
          tc[i] <= 1'b1;
        else if (tc_clr[i])
          tc[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_isa_dma_arbiter.sv
// Directed self-checking bench for isa_dma_arbiter with default parameters
// (GAP_CYCLES=2, TIMEOUT=255).
module tb_isa_dma_arbiter;
  logic        clk;
  logic        reset_n;
  logic [3:0]  ch_en;
  logic        cnt_load;
  logic [1:0]  cnt_ch;
  logic [15:0] cnt_value;
  logic [3:0]  tc_clr;
  logic [3:0]  tc;
  logic        busy;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  isa_dma_arbiter_if bus ();

  isa_dma_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .ch_en       (ch_en),
    .cnt_load    (cnt_load),
    .cnt_ch      (cnt_ch),
    .cnt_value   (cnt_value),
    .tc_clr      (tc_clr),
    .tc          (tc),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [1:0] ch, input logic [15:0] val);
    cnt_load  = 1'b1;
    cnt_ch    = ch;
    cnt_value = val;
    tick();
    cnt_load  = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int max_cycles, output int high_cycles);
    bit seen;
    seen        = 1'b0;
    high_cycles = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (bus.xfer_req === 1'b1) seen = 1'b1;
      else if (bus.dack_n === 4'hF) high_cycles++;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic count_reqs(input int cycles, output int reqs);
    reqs = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.xfer_req === 1'b1) reqs++;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      tick();
      if (busy === 1'b0) idle = 1'b1;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int hi;
    int reqs;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n       = 1'b1;
    ch_en         = 4'hF;
    cnt_load      = 1'b0;
    cnt_ch        = 2'd0;
    cnt_value     = 16'd0;
    tc_clr        = 4'h0;
    bus.drq       = 4'h0;
    bus.xfer_done = 1'b0;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst_dack_n", 32'(bus.dack_n), 32'hF);
    check("rst_xfer_req", 32'(bus.xfer_req), 32'd0);
    check("rst_xfer_ch", 32'(bus.xfer_ch), 32'd0);
    check("rst_xfer_wide", 32'(bus.xfer_wide), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    #20 reset_n = 1'b1;
    tick();

    // Single request on channel 1 with count 2: three transfers then terminal count
    load_cnt(2'd1, 16'd2);
    bus.drq = 4'b0010;
    for (int g = 0; g < 3; g++) begin
      wait_grant("single_grant", 10, hi);
      check("single_dack_n", 32'(bus.dack_n), 32'hD);
      check("single_xfer_ch", 32'(bus.xfer_ch), 32'd1);
      check("single_xfer_wide", 32'(bus.xfer_wide), 32'd0);
      check("single_busy", 32'(busy), 32'd1);
      tick();
      check("single_req_pulse", 32'(bus.xfer_req), 32'd0);
      tick();
      tick();
      bus.xfer_done = 1'b1;
      tick();
      bus.xfer_done = 1'b0;
      check("single_dack_release", 32'(bus.dack_n), 32'hF);
    end
    wait_idle("single_idle");
    check("single_tc", 32'(tc), 32'h2);
    count_reqs(12, reqs);
    check("single_no_4th", 32'(reqs), 32'd0);
    check("single_cnt_wrap", 32'(dut.cnt_q[1]), 32'hFFFF);
    bus.drq = 4'h0;

    // Rotation across all four channels from reset
    pulse_reset();
    for (int c = 0; c < 4; c++) load_cnt(2'(c), 16'hFFFF);
    bus.drq = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rot_grant", 10, hi);
      if (g > 0) check("rot_gap_high", 32'(hi >= 2), 32'd1);
      check("rot_xfer_ch", 32'(bus.xfer_ch), 32'(exp_seq[g]));
      check("rot_xfer_wide", 32'(bus.xfer_wide), 32'(exp_seq[g] >= 2'd2));
      check("rot_dack_n", 32'(bus.dack_n), 32'(~(4'b0001 << exp_seq[g]) & 4'hF));
      tick();
      bus.xfer_done = 1'b1;
      tick();
      bus.xfer_done = 1'b0;
    end
    bus.drq = 4'h0;
    wait_idle("rot_idle");

    // Timeout on channel 0: WAIT lasts exactly 255 cycles
    pulse_reset();
    load_cnt(2'd0, 16'd5);
    bus.drq = 4'b0001;
    wait_grant("to_grant", 10, hi);
    bus.drq = 4'h0;
    repeat (255) tick();
    check("to_still_wait", 32'(bus.dack_n), 32'hE);
    check("to_err_early", 32'(timeout_err), 32'd0);
    tick();
    check("to_dack_n", 32'(bus.dack_n), 32'hF);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_cnt_kept", 32'(dut.cnt_q[0]), 32'd5);
    check("to_tc", 32'(tc), 32'd0);
    wait_idle("to_idle");

    // Collision: load beats decrement on channel 2
    load_cnt(2'd2, 16'd3);
    bus.drq = 4'b0100;
    wait_grant("col_grant2", 10, hi);
    bus.drq = 4'h0;
    tick();
    bus.xfer_done = 1'b1;
    cnt_load      = 1'b1;
    cnt_ch        = 2'd2;
    cnt_value     = 16'h1234;
    tick();
    bus.xfer_done = 1'b0;
    cnt_load      = 1'b0;
    check("col_load_wins", 32'(dut.cnt_q[2]), 32'h1234);
    check("col_tc2", 32'(tc[2]), 32'd0);
    wait_idle("col_idle2");

    // Collision: terminal count set beats tc_clr on channel 1
    load_cnt(2'd1, 16'd0);
    bus.drq = 4'b0010;
    wait_grant("col_grant1", 10, hi);
    bus.drq = 4'h0;
    tick();
    bus.xfer_done = 1'b1;
    tc_clr        = 4'b0010;
    tick();
    bus.xfer_done = 1'b0;
    tc_clr        = 4'h0;
    check("col_set_wins", 32'(tc[1]), 32'd1);
    wait_idle("col_idle1");
    tc_clr = 4'b0010;
    tick();
    tc_clr = 4'h0;
    check("col_tc_clr", 32'(tc[1]), 32'd0);

    // Masked channel never granted
    ch_en   = 4'b1110;
    bus.drq = 4'b0001;
    count_reqs(10, reqs);
    check("mask_no_grant", 32'(reqs), 32'd0);
    check("mask_busy", 32'(busy), 32'd0);

    // Enable and request dropped mid-WAIT: transfer still completes and decrements
    ch_en = 4'hF;
    wait_grant("mask_grant", 10, hi);
    tick();
    ch_en   = 4'h0;
    bus.drq = 4'h0;
    tick();
    check("mask_hold_dack", 32'(bus.dack_n), 32'hE);
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    check("mask_done_dack", 32'(bus.dack_n), 32'hF);
    check("mask_done_busy", 32'(busy), 32'd1);
    check("mask_cnt_dec", 32'(dut.cnt_q[0]), 32'd4);
    ch_en = 4'hF;
    wait_idle("mask_idle");

    // Reset mid-WAIT releases DACK without a clock edge
    bus.drq = 4'b0001;
    wait_grant("rstw_grant", 10, hi);
    bus.drq = 4'h0;
    tick();
    check("rstw_in_wait", 32'(bus.dack_n), 32'hE);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_dack_n", 32'(bus.dack_n), 32'hF);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_err_clr", 32'(timeout_err), 32'd0);
    #3 reset_n = 1'b1;
    count_reqs(12, reqs);
    check("rstw_no_req", 32'(reqs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
